// File: rtl/iob_prio_arbiter.sv
// iob_prio_arbiter: registered W-way arbiter, LOW/HIGH/round-robin winner, grant locked until release
module iob_prio_arbiter #(
    parameter int    W    = 4,
    parameter string MODE = "RR",
    localparam int   IW   = $clog2(W)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cke_i,
    input  logic [W-1:0]  req_i,
    input  logic          release_i,
    output logic [W-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          busy_o
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, rr_ptr_q, rr_ptr_d, win;
    int            c;
    // Winner: later loop iterations override, so scan order is reversed to leave the preferred candidate last
    always_comb begin
        win = '0;
        c = 0;
        if (MODE == "LOW") begin
            for (int n = W - 1; n >= 0; n--) if (req_i[n]) win = IW'(n);
        end else if (MODE == "RR") begin
            for (int k = W - 1; k >= 0; k--) begin
                c = int'(rr_ptr_q) + k;
                c = c >= W ? c - W : c;
                if (req_i[IW'(c)]) win = IW'(c);
            end
        end else begin
            for (int n = 0; n < W; n++) if (req_i[n]) win = IW'(n);
        end
    end
    // Next state: grab a winner from IDLE, hold it in GRANT until released
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE && |req_i) begin
            state_d = GRANT;
            idx_d   = win;
        end else if (state_q == GRANT && release_i) begin
            state_d  = IDLE;
            idx_d    = '0;
            rr_ptr_d = idx_q == IW'(W - 1) ? '0 : idx_q + IW'(1);
        end
    end
    // State register; cke_i freezes everything, reset included
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                state_q  <= IDLE;
                idx_q    <= '0;
                rr_ptr_q <= '0;
            end else begin
                state_q  <= state_d;
                idx_q    <= idx_d;
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end
    assign busy_o      = state_q == GRANT;
    assign grant_idx_o = idx_q;
    assign grant_o     = busy_o ? W'(1) << idx_q : '0;
endmodule
